// File: rtl/key_debounce_pulse_if.sv
// Key conditioning bus: raw pins in, debounced levels and event pulses out.
interface key_debounce_pulse_if #(
    parameter int NUM_KEYS = 3
);
    logic [NUM_KEYS-1:0] key_in;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_pulse;
    logic [NUM_KEYS-1:0] key_release;
    logic                key_any;

    // Board / controller side: drives pins, consumes key events.
    modport master (
        output key_in,
        input  key_level,
        input  key_press,
        input  key_pulse,
        input  key_release,
        input  key_any
    );

    // Conditioner side: samples pins, produces key events.
    modport slave (
        input  key_in,
        output key_level,
        output key_press,
        output key_pulse,
        output key_release,
        output key_any
    );
endinterface

// File: rtl/key_debounce_pulse.sv
// Push-button conditioner: per-key 2-flop synchroniser, press/release
// debounce and optional auto-repeat, producing registered 1-cycle pulses.
module key_debounce_pulse #(
    parameter int                NUM_KEYS        = 3,
    parameter bit                KEY_ACTIVE_LOW  = 1'b1,
    parameter int                DEBOUNCE_CYCLES = 1_000_000,
    parameter int                REPEAT_DELAY    = 25_000_000,
    parameter int                REPEAT_RATE     = 5_000_000,
    parameter logic [NUM_KEYS-1:0] REPEAT_MASK   = NUM_KEYS'(3'b110)
) (
    input logic                 clk,
    input logic                 rst,
    key_debounce_pulse_if.slave bus
);

    localparam int MAX_AB  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_CNT = (MAX_AB > REPEAT_RATE) ? MAX_AB : REPEAT_RATE;
    localparam int CW      = $clog2(MAX_CNT);

    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RR_LAST  = CW'(REPEAT_RATE - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DB_PR,
        ST_HELD,
        ST_RPT,
        ST_DB_RL
    } state_t;

    logic [NUM_KEYS-1:0] pin_pressed;
    logic [NUM_KEYS-1:0] sync_q1;
    logic [NUM_KEYS-1:0] sync_q2;
    logic [NUM_KEYS-1:0] level_vec;

    // Polarity is normalised before the synchroniser so reset presets it to "released".
    assign pin_pressed = KEY_ACTIVE_LOW ? ~bus.key_in : bus.key_in;

    // Two-flop synchroniser for every key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= pin_pressed;
            sync_q2 <= sync_q1;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          press_q, press_d;
        logic          pulse_q, pulse_d;
        logic          release_q, release_d;
        logic          level_q, level_d;
        logic          p;

        assign p = sync_q2[i];

        // Per-key state, counter and registered event outputs.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                press_q   <= 1'b0;
                pulse_q   <= 1'b0;
                release_q <= 1'b0;
                level_q   <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                press_q   <= press_d;
                pulse_q   <= pulse_d;
                release_q <= release_d;
                level_q   <= level_d;
            end
        end

        // Next state, counter and pulse decode; counter clears on every state change.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            press_d   = 1'b0;
            pulse_d   = 1'b0;
            release_d = 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (p) begin
                        state_d = ST_DB_PR;
                        cnt_d   = '0;
                    end
                end
                ST_DB_PR: begin
                    if (!p) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                        press_d = 1'b1;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_HELD: begin
                    if (!p) begin
                        state_d = ST_DB_RL;
                        cnt_d   = '0;
                    end else if (REPEAT_MASK[i]) begin
                        if (cnt_q == RD_LAST) begin
                            state_d = ST_RPT;
                            cnt_d   = '0;
                            pulse_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                ST_RPT: begin
                    if (!p) begin
                        state_d = ST_DB_RL;
                        cnt_d   = '0;
                    end else if (cnt_q == RR_LAST) begin
                        cnt_d   = '0;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_DB_RL: begin
                    if (p) begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
            level_d = (state_d == ST_HELD) || (state_d == ST_RPT) || (state_d == ST_DB_RL);
        end

        assign bus.key_level[i]   = level_q;
        assign bus.key_press[i]   = press_q;
        assign bus.key_pulse[i]   = pulse_q;
        assign bus.key_release[i] = release_q;
        assign level_vec[i]       = level_q;
    end

    assign bus.key_any = |level_vec;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Bench for key_debounce_pulse: vector table, directed corner sequences and
// random pin activity checked against a run-length reference model.
module tb_key_debounce_pulse;

    localparam int          NK   = 3;
    localparam int          DB   = 4;
    localparam int          RD   = 10;
    localparam int          RR   = 3;
    localparam logic [2:0]  MASK = 3'b110;

    logic clk;
    logic rst;

    key_debounce_pulse_if #(.NUM_KEYS(NK)) bus ();

    key_debounce_pulse #(
        .NUM_KEYS(NK),
        .KEY_ACTIVE_LOW(1'b1),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR),
        .REPEAT_MASK(MASK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_total;
    int tick_no;

    // Reference model: debounced level follows runs of the synchronised input;
    // repeats are timed from the press or from the start of the current held run.
    bit s1 [NK];
    bit s2 [NK];
    bit prev_p [NK];
    bit lvl [NK];
    int run_len [NK];
    int age [NK];
    logic [NK-1:0] e_press, e_pulse, e_rel, e_lvl;

    task automatic model_reset();
        for (int k = 0; k < NK; k++) begin
            s1[k] = 0; s2[k] = 0; prev_p[k] = 0; lvl[k] = 0;
            run_len[k] = 0; age[k] = 0;
        end
        e_press = '0; e_pulse = '0; e_rel = '0; e_lvl = '0;
    endtask

    task automatic model_step(input logic [NK-1:0] pins);
        bit p;
        for (int k = 0; k < NK; k++) begin
            p = s2[k];
            s2[k] = s1[k];
            s1[k] = ~pins[k];
            if (p == prev_p[k]) run_len[k]++;
            else run_len[k] = 1;
            prev_p[k] = p;
            e_press[k] = 0; e_pulse[k] = 0; e_rel[k] = 0;
            if (!lvl[k]) begin
                if (p && run_len[k] == DB + 1) begin
                    lvl[k] = 1; e_press[k] = 1; e_pulse[k] = 1; age[k] = 0;
                end
            end else if (!p) begin
                if (run_len[k] == DB + 1) begin
                    lvl[k] = 0; e_rel[k] = 1;
                end
            end else begin
                if (run_len[k] == 1) age[k] = 0;
                else age[k]++;
                if (MASK[k] && age[k] >= RD && ((age[k] - RD) % RR) == 0) e_pulse[k] = 1;
            end
            e_lvl[k] = lvl[k];
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @tick %0d: got 0x%0h, expected 0x%0h", name, tick_no, act, exp);
    endtask

    task automatic tick(input logic [NK-1:0] pins);
        bus.key_in = pins;
        @(posedge clk);
        model_step(pins);
        tick_no++;
        #1;
        check("model", {19'd0, bus.key_level, bus.key_press, bus.key_pulse, bus.key_release, bus.key_any},
              {19'd0, e_lvl, e_press, e_pulse, e_rel, |e_lvl});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick('1);
    endtask

    typedef struct {
        int key;
        int hold;
        int exp_first_press;
        int exp_pulses;
        int exp_releases;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int np, nu, nr, first;
        logic [NK-1:0] pins;

        n_pass = 0; n_total = 0; tick_no = 0;
        vecs[0] = '{key:0, hold:40, exp_first_press:6,  exp_pulses:1, exp_releases:1};
        vecs[1] = '{key:0, hold:4,  exp_first_press:-1, exp_pulses:0, exp_releases:0};
        vecs[2] = '{key:0, hold:5,  exp_first_press:6,  exp_pulses:1, exp_releases:1};
        vecs[3] = '{key:2, hold:3,  exp_first_press:-1, exp_pulses:0, exp_releases:0};
        vecs[4] = '{key:2, hold:16, exp_first_press:6,  exp_pulses:2, exp_releases:1};
        vecs[5] = '{key:1, hold:15, exp_first_press:6,  exp_pulses:2, exp_releases:1};
        vecs[6] = '{key:1, hold:14, exp_first_press:6,  exp_pulses:1, exp_releases:1};
        vecs[7] = '{key:2, hold:20, exp_first_press:6,  exp_pulses:3, exp_releases:1};

        // Reset with all keys released.
        rst = 1'b1;
        bus.key_in = '1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {19'd0, bus.key_level, bus.key_press, bus.key_pulse, bus.key_release, bus.key_any}, 32'd0);
        rst = 1'b0;
        idle(4);

        // Vector table: press one key for 'hold' ticks then release.
        for (int v = 0; v < 8; v++) begin
            np = 0; nu = 0; nr = 0; first = -1;
            for (int t = 0; t < vecs[v].hold + 20; t++) begin
                pins = '1;
                if (t < vecs[v].hold) pins[vecs[v].key] = 1'b0;
                tick(pins);
                if (bus.key_press[vecs[v].key]) begin
                    np++;
                    if (first < 0) first = t;
                end
                if (bus.key_pulse[vecs[v].key]) nu++;
                if (bus.key_release[vecs[v].key]) nr++;
            end
            check($sformatf("vec%0d_first_press", v), first, vecs[v].exp_first_press);
            check($sformatf("vec%0d_presses", v), np, (vecs[v].exp_first_press >= 0) ? 1 : 0);
            check($sformatf("vec%0d_pulses", v), nu, vecs[v].exp_pulses);
            check($sformatf("vec%0d_releases", v), nr, vecs[v].exp_releases);
        end

        // Bounce on key 1: toggle every 2 ticks for 20 ticks, then hold low.
        for (int t = 0; t < 30; t++) begin
            pins = '1;
            if (t >= 20 || ((t / 2) % 2) == 0) pins[1] = 1'b0;
            tick(pins);
            check("bounce_press", bus.key_press[1], (t == 26));
        end
        idle(12);

        // Auto-repeat timing on key 2.
        for (int t = 0; t < 30; t++) begin
            tick(3'b011);
            check("rpt_pulse", bus.key_pulse[2], (t inside {6, 16, 19, 22, 25, 28}));
            check("rpt_press", bus.key_press[2], (t == 6));
        end
        idle(12);

        // Release bounce while repeating: repeat delay restarts from return to held.
        for (int t = 0; t < 36; t++) begin
            pins = (t == 20 || t == 21) ? 3'b111 : 3'b011;
            tick(pins);
            if (t >= 20) begin
                check("rlbounce_release", bus.key_release[2], 1'b0);
                check("rlbounce_pulse", bus.key_pulse[2], (t == 34));
            end
        end
        idle(12);

        // Simultaneous press of all keys.
        for (int t = 0; t < 10; t++) begin
            tick(3'b000);
            check("simul_press", bus.key_press, (t == 6) ? 3'b111 : 3'b000);
            check("simul_any", bus.key_any, (t >= 6));
        end
        idle(12);

        // Reset while key 2 repeats, pin kept pressed.
        for (int t = 0; t < 20; t++) tick(3'b011);
        rst = 1'b1;
        #1;
        check("reset_async", {19'd0, bus.key_level, bus.key_press, bus.key_pulse, bus.key_release, bus.key_any}, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", {19'd0, bus.key_level, bus.key_press, bus.key_pulse, bus.key_release, bus.key_any}, 32'd0);
        rst = 1'b0;
        for (int t = 0; t < 10; t++) begin
            tick(3'b011);
            check("post_reset_press", bus.key_press[2], (t == 6));
        end
        idle(12);

        // Random pin activity against the model.
        for (int s = 0; s < 200; s++) begin
            pins = NK'($urandom);
            for (int t = 0; t < int'($urandom_range(1, 24)); t++) tick(pins);
        end
        idle(12);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
